// File: rtl/mastermind_scorer_if.sv
// Handshake/result bundle between the digit-entry controller and the scorer.
interface mastermind_scorer_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_W    = 2,
    parameter int unsigned MAX_TRIES  = 8
);
    localparam int unsigned CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;

    logic              new_game;
    logic              submit;
    logic [CODE_W-1:0] guess;
    logic [CODE_W-1:0] secret;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count_correct;
    logic [CNT_W-1:0]  count_misplaced;
    logic [TRY_W-1:0]  tries_used;
    logic              win;
    logic              game_over;

    // Game controller side
    modport master (
        output new_game, submit, guess, secret,
        input  busy, done, count_correct, count_misplaced, tries_used, win, game_over
    );

    // Scorer side
    modport slave (
        input  new_game, submit, guess, secret,
        output busy, done, count_correct, count_misplaced, tries_used, win, game_over
    );
endinterface

// File: rtl/mastermind_scorer.sv
// Mastermind scorer: exact matches from a latched match mask, misplaced digits
// accumulated one symbol per cycle as sum over symbols of min(guess, secret)
// occurrences among the non-exact positions.
module mastermind_scorer #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_W    = 2,
    parameter int unsigned MAX_TRIES  = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    mastermind_scorer_if.slave   io_bus
);
    localparam int unsigned CNT_W    = $clog2(NUM_DIGITS + 1);
    localparam int unsigned TRY_W    = $clog2(MAX_TRIES + 1);
    localparam int unsigned CODE_W   = NUM_DIGITS * DIGIT_W;
    localparam int unsigned NUM_SYMS = 2 ** DIGIT_W;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

    state_t r_state, w_state_next;

    logic [CODE_W-1:0]     r_guess, r_secret;
    logic [NUM_DIGITS-1:0] r_mask;
    logic [CNT_W-1:0]      r_acc;
    logic [DIGIT_W-1:0]    r_sym;
    logic                  r_done;
    logic [CNT_W-1:0]      r_count_correct, r_count_misplaced;
    logic [TRY_W-1:0]      r_tries;
    logic                  r_win, r_game_over;

    logic                  w_clear, w_load, w_step, w_finish;
    logic [NUM_DIGITS-1:0] w_mask_in;
    logic [CNT_W-1:0]      w_gc, w_sc, w_min, w_exact;
    logic [TRY_W-1:0]      w_tries_inc;
    logic                  w_win;

    // Next-state and control strobes; new_game aborts any scoring in flight
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.new_game) begin
                    w_clear = 1'b1;
                end else if (io_bus.submit && !r_game_over) begin
                    w_load       = 1'b1;
                    w_state_next = StScan;
                end
            end
            StScan: begin
                if (io_bus.new_game) begin
                    w_clear      = 1'b1;
                    w_state_next = StIdle;
                end else begin
                    w_step = 1'b1;
                    if (r_sym == DIGIT_W'(NUM_SYMS - 1)) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
                if (io_bus.new_game) begin
                    w_clear = 1'b1;
                end else begin
                    w_finish = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Per-symbol occurrence counts over non-exact positions, match mask and popcount
    always_comb begin
        w_gc      = '0;
        w_sc      = '0;
        w_exact   = '0;
        w_mask_in = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_mask_in[i] = (io_bus.guess[i*DIGIT_W +: DIGIT_W] ==
                            io_bus.secret[i*DIGIT_W +: DIGIT_W]);
            if (r_mask[i]) begin
                w_exact = w_exact + CNT_W'(1);
            end else begin
                if (r_guess[i*DIGIT_W +: DIGIT_W] == r_sym) w_gc = w_gc + CNT_W'(1);
                if (r_secret[i*DIGIT_W +: DIGIT_W] == r_sym) w_sc = w_sc + CNT_W'(1);
            end
        end
        w_min       = (w_gc < w_sc) ? w_gc : w_sc;
        w_tries_inc = r_tries + TRY_W'(1);
        w_win       = (w_exact == CNT_W'(NUM_DIGITS));
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // Datapath: operand latch, accumulation and result/game-state registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_guess           <= '0;
            r_secret          <= '0;
            r_mask            <= '0;
            r_acc             <= '0;
            r_sym             <= '0;
            r_done            <= 1'b0;
            r_count_correct   <= '0;
            r_count_misplaced <= '0;
            r_tries           <= '0;
            r_win             <= 1'b0;
            r_game_over       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_clear) begin
                r_count_correct   <= '0;
                r_count_misplaced <= '0;
                r_tries           <= '0;
                r_win             <= 1'b0;
                r_game_over       <= 1'b0;
            end
            if (w_load) begin
                r_guess  <= io_bus.guess;
                r_secret <= io_bus.secret;
                r_mask   <= w_mask_in;
                r_acc    <= '0;
                r_sym    <= '0;
            end
            if (w_step) begin
                r_acc <= r_acc + w_min;
                r_sym <= r_sym + DIGIT_W'(1);
            end
            if (w_finish) begin
                r_done            <= 1'b1;
                r_count_correct   <= w_exact;
                r_count_misplaced <= r_acc;
                if (r_tries != TRY_W'(MAX_TRIES)) r_tries <= w_tries_inc;
                r_win       <= w_win;
                r_game_over <= w_win | (w_tries_inc == TRY_W'(MAX_TRIES));
            end
        end
    end

    assign io_bus.busy            = (r_state != StIdle);
    assign io_bus.done            = r_done;
    assign io_bus.count_correct   = r_count_correct;
    assign io_bus.count_misplaced = r_count_misplaced;
    assign io_bus.tries_used      = r_tries;
    assign io_bus.win             = r_win;
    assign io_bus.game_over       = r_game_over;
endmodule

// File: tb/tb_mastermind_scorer.sv
// Self-checking bench: directed cases plus random games against a histogram-based model.
module tb_mastermind_scorer;
    localparam int unsigned ND   = 4;
    localparam int unsigned DW   = 2;
    localparam int unsigned MT   = 8;
    localparam int unsigned CW   = ND * DW;
    localparam int unsigned NSYM = 2 ** DW;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    mastermind_scorer_if #(.NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_TRIES(MT)) bus_if ();

    mastermind_scorer #(.NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_TRIES(MT)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .io_bus   (bus_if)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the visible game state
    int m_cc, m_cm, m_tries;
    int m_win, m_over;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Exact = equal positions; misplaced = sum_sym min(#g, #s) over all positions minus exact
    function automatic void ref_score(input logic [CW-1:0] g, input logic [CW-1:0] s,
                                      output int ex, output int mis);
        int hg[NSYM];
        int hs[NSYM];
        int common;
        for (int k = 0; k < NSYM; k++) begin
            hg[k] = 0;
            hs[k] = 0;
        end
        ex = 0;
        for (int i = 0; i < ND; i++) begin
            int gd, sd;
            gd = int'((g >> (i * DW)) & CW'(NSYM - 1));
            sd = int'((s >> (i * DW)) & CW'(NSYM - 1));
            if (gd == sd) ex++;
            hg[gd]++;
            hs[sd]++;
        end
        common = 0;
        for (int k = 0; k < NSYM; k++) common += (hg[k] < hs[k]) ? hg[k] : hs[k];
        mis = common - ex;
    endfunction

    task automatic model_clear();
        m_cc = 0; m_cm = 0; m_tries = 0; m_win = 0; m_over = 0;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_correct"},   32'(bus_if.count_correct),   m_cc);
        check({tag, "_misplaced"}, 32'(bus_if.count_misplaced), m_cm);
        check({tag, "_tries"},     32'(bus_if.tries_used),      m_tries);
        check({tag, "_win"},       32'(bus_if.win),             m_win);
        check({tag, "_game_over"}, 32'(bus_if.game_over),       m_over);
    endtask

    task automatic watch(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bus_if.done) pulses++;
        end
    endtask

    task automatic new_game();
        bus_if.new_game = 1'b1;
        tick();
        bus_if.new_game = 1'b0;
        model_clear();
    endtask

    // Full scoring transaction with latency, pulse width and result checks
    task automatic score(input logic [CW-1:0] g, input logic [CW-1:0] s, input bit scramble,
                         input string tag);
        int lat, ex, mis;
        bus_if.guess  = g;
        bus_if.secret = s;
        bus_if.submit = 1'b1;
        tick();
        bus_if.submit = 1'b0;
        check({tag, "_busy"}, 32'(bus_if.busy), 1);
        if (scramble) begin
            bus_if.guess  = ~g;
            bus_if.secret = ~s;
        end
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus_if.done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, NSYM + 1);
        ref_score(g, s, ex, mis);
        m_cc    = ex;
        m_cm    = mis;
        m_tries = (m_tries < MT) ? m_tries + 1 : m_tries;
        m_win   = (ex == ND) ? 1 : 0;
        m_over  = (m_win != 0 || m_tries == MT) ? 1 : 0;
        check_outputs(tag);
        tick();
        check({tag, "_done_width"}, 32'(bus_if.done), 0);
        check({tag, "_idle"}, 32'(bus_if.busy), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        bus_if.new_game = 1'b0;
        bus_if.submit   = 1'b0;
        bus_if.guess    = '0;
        bus_if.secret   = '0;
        model_clear();

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_outputs("reset");
        check("reset_busy", 32'(bus_if.busy), 0);
        check("reset_done", 32'(bus_if.done), 0);

        // Winning guess
        score(8'hE4, 8'hE4, 1'b0, "t1");

        // Permutation: all misplaced
        new_game();
        score(8'h1B, 8'hE4, 1'b0, "t2");

        // Duplicate symbols
        new_game();
        score(8'h00, 8'h50, 1'b0, "t3a");
        score(8'h81, 8'h50, 1'b0, "t3b");

        // Exhaust tries, then ignored submit, then new game
        new_game();
        for (int n = 0; n < MT; n++) score(8'h55, 8'hE4, 1'b0, "t4");
        bus_if.guess  = 8'hE4;
        bus_if.secret = 8'hE4;
        bus_if.submit = 1'b1;
        tick();
        bus_if.submit = 1'b0;
        check("t4_ignored_busy", 32'(bus_if.busy), 0);
        watch(10, pulses);
        check("t4_ignored_done", pulses, 0);
        check_outputs("t4_ignored");
        new_game();
        check_outputs("t4_newgame");

        // Second submit during SCAN is dropped
        bus_if.guess  = 8'h1B;
        bus_if.secret = 8'hE4;
        bus_if.submit = 1'b1;
        tick();
        bus_if.submit = 1'b0;
        tick();
        bus_if.guess  = 8'hE4;
        bus_if.submit = 1'b1;
        tick();
        bus_if.submit = 1'b0;
        watch(12, pulses);
        check("t5a_pulses", pulses, 1);
        m_cc = 0; m_cm = 4; m_tries = 1; m_win = 0; m_over = 0;
        check_outputs("t5a");

        // new_game aborts scoring
        bus_if.guess  = 8'h55;
        bus_if.submit = 1'b1;
        tick();
        bus_if.submit = 1'b0;
        tick();
        bus_if.new_game = 1'b1;
        tick();
        bus_if.new_game = 1'b0;
        model_clear();
        watch(10, pulses);
        check("t5b_pulses", pulses, 0);
        check("t5b_busy", 32'(bus_if.busy), 0);
        check_outputs("t5b");

        // Reset during SCAN
        score(8'h81, 8'h50, 1'b0, "t5c_pre");
        bus_if.submit = 1'b1;
        tick();
        bus_if.submit = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check_outputs("t5c");
        check("t5c_busy", 32'(bus_if.busy), 0);
        watch(10, pulses);
        check("t5c_pulses", pulses, 0);

        // new_game and submit together
        score(8'h00, 8'h50, 1'b0, "t6a_pre");
        bus_if.new_game = 1'b1;
        bus_if.submit   = 1'b1;
        tick();
        bus_if.new_game = 1'b0;
        bus_if.submit   = 1'b0;
        model_clear();
        watch(10, pulses);
        check("t6a_pulses", pulses, 0);
        check_outputs("t6a");

        // Inputs changing during SCAN have no effect
        score(8'h81, 8'h50, 1'b1, "t6b");

        // Random games
        for (int game = 0; game < 20; game++) begin
            logic [CW-1:0] s, g;
            new_game();
            s = CW'($urandom);
            while (m_over == 0) begin
                g = ($urandom_range(0, 5) == 0) ? s : CW'($urandom);
                score(g, s, 1'($urandom_range(0, 1)), "rnd");
            end
            if ($urandom_range(0, 1) == 1) begin
                bus_if.submit = 1'b1;
                tick();
                bus_if.submit = 1'b0;
                watch(8, pulses);
                check("rnd_over_pulses", pulses, 0);
                check_outputs("rnd_over");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
